frame_buf_sched: RTL and testbench

Ownership scheduler for a multi-buffer frame store shared by one capture writer and one DI-bus reader. It hands free buffers to the writer at frame start and queues completed frames in arrival order. It gives the oldest completed frame to the reader and reclaims buffers on release. It applies a configurable policy when the writer finds no free buffer. It sits between the stream frame-start/end decode and the buffer RAM address/select logic, replacing ad-hoc ping-pong toggling.

---
 rtl/frame_buf_sched_pkg.sv | 18 +
 rtl/buf_idx_fifo.sv | 59 +++++
 rtl/frame_buf_sched.sv | 178 +++++++++++++++++
 tb/tb_frame_buf_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_sched_pkg.sv
// Shared definitions for the frame buffer ownership scheduler.
//   buf_state_t : per-buffer ownership state (FREE/WRITING/READY/READING)
//   wr_state_t  : capture-writer state (idle / writing a frame)
package frame_buf_sched_pkg;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/buf_idx_fifo.sv
// Ready-frame FIFO of buffer indices, oldest entry at head0.
//   clki/reset     : clock, synchronous active-high clear
//   push/push_idx  : append an index behind the current contents
//   pop_a/pop_b    : independent pops; both together remove two entries
//   head0/head1    : oldest and second-oldest entries
//   count          : number of valid entries
// The pop count is applied before the push, so an entry pushed this cycle is
// never visible at head0/head1 until the next cycle.
module buf_idx_fifo #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clki,
  input  logic                 reset,
  input  logic                 push,
  input  logic [IDX_WIDTH-1:0] push_idx,
  input  logic                 pop_a,
  input  logic                 pop_b,
  output logic [IDX_WIDTH-1:0] head0,
  output logic [IDX_WIDTH-1:0] head1,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int unsigned MW = DEPTH * IDX_WIDTH;
  localparam logic [MW-1:0] SLOT_MASK = MW'((1 << IDX_WIDTH) - 1);

  logic [MW-1:0]        mem_q, mem_n;
  logic [CNT_WIDTH-1:0] count_q, count_n, npop, wpos;

  // Entries live packed at the low end; a pop is a right shift, which keeps
  // every slot above count zero.
  always_comb begin
    npop    = CNT_WIDTH'(pop_a) + CNT_WIDTH'(pop_b);
    wpos    = count_q - npop;
    mem_n   = mem_q >> (npop * IDX_WIDTH);
    count_n = wpos;
    if (push) begin
      mem_n   = (mem_n & ~(SLOT_MASK << (wpos * IDX_WIDTH)))
              | (MW'(push_idx) << (wpos * IDX_WIDTH));
      count_n = wpos + 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_n;
      count_q <= count_n;
    end
  end

  assign head0 = mem_q[IDX_WIDTH-1:0];
  assign head1 = mem_q[2*IDX_WIDTH-1:IDX_WIDTH];
  assign count = count_q;

endmodule

// File: rtl/frame_buf_sched.sv
// Ownership scheduler for a multi-buffer frame store with one capture writer
// and one DI-bus reader.
//   clki, reset, enable            : clock, sync reset, soft clear (counters kept)
//   wr_start/wr_end/wr_len/wr_abort: writer frame events
//   wr_grant/wr_buf                : buffer currently owned by the writer
//   rd_req                         : reader level request
//   rd_rdy/rd_buf/rd_len           : buffer owned by the reader and its length
//   ready_count                    : buffers waiting in the ready FIFO
//   frames_captured/frames_dropped : wrapping statistics
module frame_buf_sched
  import frame_buf_sched_pkg::*;
#(
  parameter int unsigned NUM_BUFS  = 2,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned LEN_WIDTH = 22,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                 clki,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 wr_start,
  input  logic                 wr_end,
  input  logic [LEN_WIDTH-1:0] wr_len,
  input  logic                 wr_abort,
  output logic                 wr_grant,
  output logic [IDX_WIDTH-1:0] wr_buf,
  input  logic                 rd_req,
  output logic                 rd_rdy,
  output logic [IDX_WIDTH-1:0] rd_buf,
  output logic [LEN_WIDTH-1:0] rd_len,
  output logic [IDX_WIDTH:0]   ready_count,
  output logic [15:0]          frames_captured,
  output logic [15:0]          frames_dropped
);

  localparam int unsigned NSLOT     = 1 << IDX_WIDTH;
  localparam int unsigned CNT_WIDTH = IDX_WIDTH + 1;

  buf_state_t           bst_q [NSLOT];
  buf_state_t           bst_n [NSLOT];
  logic [LEN_WIDTH-1:0] len_q [NSLOT];
  wr_state_t            wst_q, wst_n;
  logic [IDX_WIDTH-1:0] wr_buf_q, wr_buf_n, rd_buf_q, rd_buf_n;
  logic [IDX_WIDTH-1:0] free_idx, alloc_idx, head0, head1;
  logic [LEN_WIDTH-1:0] rd_len_q, rd_len_n;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic                 rd_rdy_q, rd_rdy_n;
  logic                 end_ev, abort_ev, writer_free, free_found, alloc;
  logic                 rd_grant, rd_release, ow_pop, drop_ev, clear;

  assign clear = reset | ~enable;

  buf_idx_fifo #(
    .DEPTH     (NUM_BUFS),
    .IDX_WIDTH (IDX_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ready_fifo (
    .clki     (clki),
    .reset    (clear),
    .push     (end_ev),
    .push_idx (wr_buf_q),
    .pop_a    (rd_grant),
    .pop_b    (ow_pop),
    .head0    (head0),
    .head1    (head1),
    .count    (fifo_count)
  );

  always_comb begin
    bst_n      = bst_q;
    wst_n      = wst_q;
    wr_buf_n   = wr_buf_q;
    rd_rdy_n   = rd_rdy_q;
    rd_buf_n   = rd_buf_q;
    rd_len_n   = rd_len_q;
    free_found = 1'b0;
    free_idx   = '0;
    alloc      = 1'b0;
    alloc_idx  = '0;
    ow_pop     = 1'b0;
    drop_ev    = 1'b0;

    end_ev   = (wst_q == W_ACTIVE) && wr_end;
    abort_ev = (wst_q == W_ACTIVE) && wr_abort && !wr_end;
    if (end_ev)   bst_n[wr_buf_q] = BUF_READY;
    if (abort_ev) bst_n[wr_buf_q] = BUF_FREE;
    if (end_ev || abort_ev) wst_n = W_IDLE;
    writer_free = (wst_q == W_IDLE) || end_ev || abort_ev;

    // Lowest FREE index, searched after end/abort so a just-finished buffer
    // (now READY) is excluded.
    for (int unsigned i = NUM_BUFS; i > 0; i--) begin
      if (bst_n[i-1] == BUF_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(i - 1);
      end
    end

    rd_grant   = rd_req && !rd_rdy_q && (fifo_count != '0);
    rd_release = !rd_req && rd_rdy_q;

    // Overwrite only sees entries present before this cycle's push; when the
    // reader also pops, the writer takes the second-oldest entry.
    if (wr_start) begin
      if (!writer_free) begin
        drop_ev = 1'b1;
      end else if (free_found) begin
        alloc     = 1'b1;
        alloc_idx = free_idx;
      end else if ((OVERWRITE != 0) && (fifo_count > CNT_WIDTH'(rd_grant))) begin
        ow_pop    = 1'b1;
        drop_ev   = 1'b1;
        alloc     = 1'b1;
        alloc_idx = rd_grant ? head1 : head0;
      end else begin
        drop_ev = 1'b1;
      end
    end

    if (alloc) begin
      bst_n[alloc_idx] = BUF_WRITING;
      wst_n            = W_ACTIVE;
      wr_buf_n         = alloc_idx;
    end

    if (rd_grant) begin
      bst_n[head0] = BUF_READING;
      rd_rdy_n     = 1'b1;
      rd_buf_n     = head0;
      rd_len_n     = len_q[head0];
    end

    if (rd_release) begin
      bst_n[rd_buf_q] = BUF_FREE;
      rd_rdy_n        = 1'b0;
    end
  end

  always_ff @(posedge clki) begin
    if (clear) begin
      wst_q    <= W_IDLE;
      wr_buf_q <= '0;
      rd_rdy_q <= 1'b0;
      rd_buf_q <= '0;
      rd_len_q <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) bst_q[i] <= BUF_FREE;
    end else begin
      wst_q    <= wst_n;
      wr_buf_q <= wr_buf_n;
      rd_rdy_q <= rd_rdy_n;
      rd_buf_q <= rd_buf_n;
      rd_len_q <= rd_len_n;
      bst_q    <= bst_n;
    end
  end

  always_ff @(posedge clki) begin
    if (enable && end_ev) len_q[wr_buf_q] <= wr_len;
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      frames_captured <= '0;
      frames_dropped  <= '0;
    end else if (enable) begin
      frames_captured <= frames_captured + 16'(end_ev);
      frames_dropped  <= frames_dropped + 16'(drop_ev);
    end
  end

  assign wr_grant    = (wst_q == W_ACTIVE);
  assign wr_buf      = wr_buf_q;
  assign rd_rdy      = rd_rdy_q;
  assign rd_buf      = rd_buf_q;
  assign rd_len      = rd_len_q;
  assign ready_count = fifo_count;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched: one instance with the drop policy
// (index 0) and one with the overwrite policy (index 1), sharing stimulus.
module tb_frame_buf_sched;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned LEN_W = 22;
  localparam int unsigned NB    = 2;

  logic clki = 1'b0;
  always #5 clki = ~clki;

  logic             reset, enable, wr_start, wr_end, wr_abort, rd_req;
  logic [LEN_W-1:0] wr_len;

  logic [1:0]            wr_grant_o, rd_rdy_o;
  logic [1:0][IDX_W-1:0] wr_buf_o, rd_buf_o;
  logic [1:0][LEN_W-1:0] rd_len_o;
  logic [1:0][IDX_W:0]   ready_count_o;
  logic [1:0][15:0]      cap_o, drop_o;

  int checks = 0;
  int passed = 0;
  logic run_chk = 1'b0;

  frame_buf_sched #(
    .NUM_BUFS(NB), .IDX_WIDTH(IDX_W), .LEN_WIDTH(LEN_W), .OVERWRITE(0)
  ) u_dut0 (
    .clki(clki), .reset(reset), .enable(enable),
    .wr_start(wr_start), .wr_end(wr_end), .wr_len(wr_len), .wr_abort(wr_abort),
    .wr_grant(wr_grant_o[0]), .wr_buf(wr_buf_o[0]),
    .rd_req(rd_req), .rd_rdy(rd_rdy_o[0]), .rd_buf(rd_buf_o[0]), .rd_len(rd_len_o[0]),
    .ready_count(ready_count_o[0]), .frames_captured(cap_o[0]), .frames_dropped(drop_o[0])
  );

  frame_buf_sched #(
    .NUM_BUFS(NB), .IDX_WIDTH(IDX_W), .LEN_WIDTH(LEN_W), .OVERWRITE(1)
  ) u_dut1 (
    .clki(clki), .reset(reset), .enable(enable),
    .wr_start(wr_start), .wr_end(wr_end), .wr_len(wr_len), .wr_abort(wr_abort),
    .wr_grant(wr_grant_o[1]), .wr_buf(wr_buf_o[1]),
    .rd_req(rd_req), .rd_rdy(rd_rdy_o[1]), .rd_buf(rd_buf_o[1]), .rd_len(rd_len_o[1]),
    .ready_count(ready_count_o[1]), .frames_captured(cap_o[1]), .frames_dropped(drop_o[1])
  );

  // Inputs and expected outputs after one clock; -1 means "not checked".
  typedef struct {
    int s, e, a, rq, en, len;
    int g, wb, rr, rb, rl, rc, cap, drop;
  } vec_t;

  vec_t tbl [10];

  // Ready FIFO can never hold more than NUM_BUFS entries.
  always @(negedge clki) begin
    if (run_chk) begin
      checks++;
      if (ready_count_o[0] <= NB && ready_count_o[1] <= NB) passed++;
      else $display("FAIL fifo_bound: got %0d/%0d, expected <= %0d",
                    ready_count_o[0], ready_count_o[1], NB);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input int e, input int a, input int rq,
                       input int en, input int len);
    wr_start = (s != 0);
    wr_end   = (e != 0);
    wr_abort = (a != 0);
    rd_req   = (rq != 0);
    enable   = (en != 0);
    wr_len   = LEN_W'(len);
    @(posedge clki);
    #1;
    wr_start = 1'b0;
    wr_end   = 1'b0;
    wr_abort = 1'b0;
  endtask

  task automatic expect_dut(input int d, input string tag,
                            input int g, input int wb, input int rr, input int rb,
                            input int rl, input int rc, input int cap, input int drop);
    chk($sformatf("%s dut%0d wr_grant", tag, d),    int'(wr_grant_o[d]),    g);
    chk($sformatf("%s dut%0d wr_buf", tag, d),      int'(wr_buf_o[d]),      wb);
    chk($sformatf("%s dut%0d rd_rdy", tag, d),      int'(rd_rdy_o[d]),      rr);
    chk($sformatf("%s dut%0d rd_buf", tag, d),      int'(rd_buf_o[d]),      rb);
    chk($sformatf("%s dut%0d rd_len", tag, d),      int'(rd_len_o[d]),      rl);
    chk($sformatf("%s dut%0d ready_count", tag, d), int'(ready_count_o[d]), rc);
    chk($sformatf("%s dut%0d captured", tag, d),    int'(cap_o[d]),         cap);
    chk($sformatf("%s dut%0d dropped", tag, d),     int'(drop_o[d]),        drop);
  endtask

  task automatic expect_both(input string tag,
                             input int g, input int wb, input int rr, input int rb,
                             input int rl, input int rc, input int cap, input int drop);
    expect_dut(0, tag, g, wb, rr, rb, rl, rc, cap, drop);
    expect_dut(1, tag, g, wb, rr, rb, rl, rc, cap, drop);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    expect_both(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; wr_start = 1'b0; wr_end = 1'b0;
    wr_abort = 1'b0; rd_req = 1'b0; wr_len = '0;

    //            s  e  a rq en len   g wb rr rb  rl  rc cap drop
    tbl[0] = '{   1, 0, 0, 0, 1,  0,  1, 0, 0, 0,   0, 0, 0, 0};
    tbl[1] = '{   0, 0, 0, 0, 1,  0,  1, 0, 0, 0,   0, 0, 0, 0};
    tbl[2] = '{   0, 1, 0, 0, 1,100,  0, 0, 0, 0,   0, 1, 1, 0};
    tbl[3] = '{   1, 0, 0, 0, 1,  0,  1, 1, 0, 0,   0, 1, 1, 0};
    tbl[4] = '{   0, 1, 0, 0, 1,200,  0, 1, 0, 0,   0, 2, 2, 0};
    tbl[5] = '{   0, 0, 0, 1, 1,  0,  0, 1, 1, 0, 100, 1, 2, 0};
    tbl[6] = '{   0, 0, 0, 1, 1,  0,  0, 1, 1, 0, 100, 1, 2, 0};
    tbl[7] = '{   0, 0, 0, 0, 1,  0,  0, 1, 0,-1,  -1, 1, 2, 0};
    tbl[8] = '{   0, 0, 0, 1, 1,  0,  0, 1, 1, 1, 200, 0, 2, 0};
    tbl[9] = '{   0, 0, 0, 0, 1,  0,  0, 1, 0,-1,  -1, 0, 2, 0};

    drive(0, 0, 0, 0, 1, 0);
    do_reset("reset");
    run_chk = 1'b1;

    // Two frames, read back in arrival order.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].s, tbl[i].e, tbl[i].a, tbl[i].rq, tbl[i].en, tbl[i].len);
      expect_both($sformatf("vec%0d", i), tbl[i].g, tbl[i].wb, tbl[i].rr, tbl[i].rb,
                  tbl[i].rl, tbl[i].rc, tbl[i].cap, tbl[i].drop);
    end

    // Three frames with no reader: drop vs overwrite oldest.
    do_reset("rst_ow");
    drive(1, 0, 0, 0, 1, 0);  expect_both("ow_s1", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 11); expect_both("ow_e1", 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 0);  expect_both("ow_s2", 1, 1, 0, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 1, 22); expect_both("ow_e2", 0, 1, 0, 0, 0, 2, 2, 0);
    drive(1, 0, 0, 0, 1, 0);
    expect_dut(0, "ow_s3", 0, 1, 0, 0, 0, 2, 2, 1);
    expect_dut(1, "ow_s3", 1, 0, 0, 0, 0, 1, 2, 1);
    drive(0, 1, 0, 0, 1, 33);
    expect_dut(0, "ow_e3", 0, -1, 0, 0, 0, 2, 2, 1);
    expect_dut(1, "ow_e3", 0, -1, 0, 0, 0, 2, 3, 1);
    drive(0, 0, 0, 1, 1, 0);
    expect_dut(0, "ow_rd1", -1, -1, 1, 0, 11, 1, 2, 1);
    expect_dut(1, "ow_rd1", -1, -1, 1, 1, 22, 1, 3, 1);
    drive(0, 0, 0, 0, 1, 0);  expect_both("ow_rel1", 0, -1, 0, -1, -1, 1, -1, 1);
    drive(0, 0, 0, 1, 1, 0);
    expect_dut(0, "ow_rd2", -1, -1, 1, 1, 22, 0, 2, 1);
    expect_dut(1, "ow_rd2", -1, -1, 1, 0, 33, 0, 3, 1);
    drive(0, 0, 0, 0, 1, 0);  expect_both("ow_rel2", 0, -1, 0, -1, -1, 0, -1, 1);

    // End+start in one cycle, then a simultaneous reader and overwrite pop.
    do_reset("rst_es");
    drive(1, 0, 0, 0, 1, 0);  expect_both("es_s1", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1);  expect_both("es_e1", 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 0);  expect_both("es_s2", 1, 1, 0, 0, 0, 1, 1, 0);
    drive(1, 1, 0, 0, 1, 2);
    expect_dut(0, "es_es", 0, 1, 0, 0, 0, 2, 2, 1);
    expect_dut(1, "es_es", 1, 0, 0, 0, 0, 1, 2, 1);
    drive(0, 1, 0, 0, 1, 3);
    expect_dut(0, "es_e3", 0, -1, 0, 0, 0, 2, 2, 1);
    expect_dut(1, "es_e3", 0, -1, 0, 0, 0, 2, 3, 1);
    drive(1, 0, 0, 1, 1, 0);
    expect_dut(0, "dual", 0, -1, 1, 0, 1, 1, 2, 2);
    expect_dut(1, "dual", 1, 0, 1, 1, 2, 0, 3, 2);
    drive(0, 1, 0, 0, 1, 4);
    expect_dut(0, "dual_e", 0, -1, 0, -1, -1, 1, 2, 2);
    expect_dut(1, "dual_e", 0, -1, 0, -1, -1, 1, 4, 2);

    // Reader holds buffer 0 while the writer works on buffer 1.
    do_reset("rst_rh");
    drive(1, 0, 0, 0, 1, 0);  expect_both("rh_s1", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 5);  expect_both("rh_e1", 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);  expect_both("rh_rd", 0, 0, 1, 0, 5, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 0);  expect_both("rh_s2", 1, 1, 1, 0, 5, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 0);  expect_both("rh_miss", 1, 1, 1, 0, 5, 0, 1, 1);
    drive(0, 1, 0, 1, 1, 6);  expect_both("rh_e2", 0, 1, 1, 0, 5, 1, 2, 1);
    drive(1, 0, 0, 1, 1, 0);
    expect_dut(0, "rh_s3", 0, 1, 1, 0, 5, 1, 2, 2);
    expect_dut(1, "rh_s3", 1, 1, 1, 0, 5, 0, 2, 2);
    drive(0, 0, 0, 0, 1, 0);  expect_both("rh_rel", -1, 1, 0, -1, -1, -1, 2, 2);

    // Abort, stray end in idle, no FIFO bypass, then enable drop.
    do_reset("rst_ab");
    drive(1, 0, 0, 0, 1, 0);  expect_both("ab_s1", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 0);  expect_both("ab_abort", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);  expect_both("ab_s2", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 50); expect_both("ab_e", 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 1, 1, 0);  expect_both("ab_rd", 0, 0, 1, 0, 50, 0, 1, 0);
    drive(1, 0, 0, 1, 1, 0);  expect_both("ab_s3", 1, 1, 1, 0, 50, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);  expect_both("en_low", 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0);  expect_both("en_back", 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    do_reset("rst_end");
    run_chk = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
